// File: rtl/ram_port_arbiter.sv
// Issue stage in front of a synchronous dual-port RAM: serialises same-address
// hazards between clients A and B round-robin, and returns reads after 2 cycles.
module ram_port_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              ram_we_a,
   output logic              ram_we_b,
   output logic [ADDR_W-1:0] ram_aadr,
   output logic [ADDR_W-1:0] ram_badr,
   output logic [DATA_W-1:0] ram_din_a,
   output logic [DATA_W-1:0] ram_din_b,
   input  logic [DATA_W-1:0] ram_dout_a,
   input  logic [DATA_W-1:0] ram_dout_b,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic              w_conflict;
   logic              w_a_acc;
   logic              w_b_acc;
   logic              r_prio;
   logic              r_rd_pend_a;
   logic              r_rd_pend_b;
   logic              r_a_rvalid;
   logic              r_b_rvalid;
   logic              r_we_a;
   logic              r_we_b;
   logic [ADDR_W-1:0] r_adr_a;
   logic [ADDR_W-1:0] r_adr_b;
   logic [DATA_W-1:0] r_din_a;
   logic [DATA_W-1:0] r_din_b;
   logic [CNT_W-1:0]  r_cnt;

   // Two reads of one address are harmless; any write to a shared address is a hazard.
   assign w_conflict = a_valid & b_valid & (a_addr == b_addr) & (a_we | b_we);
   assign a_ready    = ~w_conflict | ~r_prio;
   assign b_ready    = ~w_conflict |  r_prio;
   assign w_a_acc    = a_valid & a_ready;
   assign w_b_acc    = b_valid & b_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we_a      <= 1'b0;
         r_rd_pend_a <= 1'b0;
         r_adr_a     <= '0;
         r_din_a     <= '0;
      end else begin
         r_we_a      <= w_a_acc & a_we;
         r_rd_pend_a <= w_a_acc & ~a_we;
         if (w_a_acc) begin
            r_adr_a <= a_addr;
            r_din_a <= a_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we_b      <= 1'b0;
         r_rd_pend_b <= 1'b0;
         r_adr_b     <= '0;
         r_din_b     <= '0;
      end else begin
         r_we_b      <= w_b_acc & b_we;
         r_rd_pend_b <= w_b_acc & ~b_we;
         if (w_b_acc) begin
            r_adr_b <= b_addr;
            r_din_b <= b_wdata;
         end
      end
   end

   // The RAM registers its output one edge after the issue register, so the
   // read-pending flag is delayed once more to line up with ram_dout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
      end else begin
         r_a_rvalid <= r_rd_pend_a;
         r_b_rvalid <= r_rd_pend_b;
      end
   end

   // On a conflict the loser is favoured next time, so prio simply flips.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prio <= 1'b0;
         r_cnt  <= '0;
      end else if (w_conflict) begin
         r_prio <= ~r_prio;
         if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign ram_we_a     = r_we_a;
   assign ram_we_b     = r_we_b;
   assign ram_aadr     = r_adr_a;
   assign ram_badr     = r_adr_b;
   assign ram_din_a    = r_din_a;
   assign ram_din_b    = r_din_b;
   assign a_rvalid     = r_a_rvalid;
   assign b_rvalid     = r_b_rvalid;
   assign a_rdata      = ram_dout_a;
   assign b_rdata      = ram_dout_b;
   assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM plus a transaction-level model
// (acceptance rules, memory image, read-due table) checked every cycle.
module tb_ram_port_arbiter;
   localparam int DW   = 16;
   localparam int AW   = 4;
   localparam int CW   = 16;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic rst;
   logic a_valid, a_we, b_valid, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic a_ready, b_ready, a_rvalid, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic ram_we_a, ram_we_b;
   logic [AW-1:0] ram_aadr, ram_badr;
   logic [DW-1:0] ram_din_a, ram_din_b;
   logic [DW-1:0] ram_dout_a = '0;
   logic [DW-1:0] ram_dout_b = '0;
   logic [CW-1:0] conflict_cnt;

   logic a_ready2, b_ready2, a_rvalid2, b_rvalid2;
   logic [DW-1:0] a_rdata2, b_rdata2;
   logic ram_we_a2, ram_we_b2;
   logic [AW-1:0] ram_aadr2, ram_badr2;
   logic [DW-1:0] ram_din_a2, ram_din_b2;
   logic [1:0] cnt2;

   logic [DW-1:0] ram_mem [2**AW] = '{default: '0};

   always #5 clk = ~clk;

   ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_we_a(ram_we_a), .ram_we_b(ram_we_b), .ram_aadr(ram_aadr), .ram_badr(ram_badr),
      .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
      .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
      .conflict_cnt(conflict_cnt)
   );

   // Narrow-counter instance shares the stimulus; only its counter is checked.
   ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready2), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
      .b_valid(b_valid), .b_ready(b_ready2), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rvalid(b_rvalid2), .b_rdata(b_rdata2),
      .ram_we_a(ram_we_a2), .ram_we_b(ram_we_b2), .ram_aadr(ram_aadr2), .ram_badr(ram_badr2),
      .ram_din_a(ram_din_a2), .ram_din_b(ram_din_b2),
      .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
      .conflict_cnt(cnt2)
   );

   // Behavioural synchronous dual-port RAM with registered read.
   always @(posedge clk) begin
      if (ram_we_a) ram_mem[ram_aadr] <= ram_din_a;
      if (ram_we_b) ram_mem[ram_badr] <= ram_din_b;
      ram_dout_a <= ram_mem[ram_aadr];
      ram_dout_b <= ram_mem[ram_badr];
   end

   // Model state: what the outputs must look like after the most recent edge.
   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [DW-1:0] m_mem [2**AW] = '{default: '0};
   bit m_prio = 1'b0;
   int m_cnt  = 0;
   bit e_iss_a = 0, e_iss_b = 0, e_we_a = 0, e_we_b = 0;
   logic [AW-1:0] e_adr_a = '0, e_adr_b = '0;
   logic [DW-1:0] e_din_a = '0, e_din_b = '0;
   bit rv_a [MAXC];
   bit rv_b [MAXC];
   logic [DW-1:0] rd_a [MAXC];
   logic [DW-1:0] rd_b [MAXC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic compare_outputs();
      bit hz;
      hz = (ram_we_a && ram_we_b && ram_aadr == ram_badr) ||
           (ram_we_a && e_iss_b && !e_we_b && ram_aadr == ram_badr) ||
           (ram_we_b && e_iss_a && !e_we_a && ram_aadr == ram_badr);
      check("ram_hazard", 32'(hz), 32'd0);
      check("ram_we_a", 32'(ram_we_a), 32'(e_we_a));
      check("ram_we_b", 32'(ram_we_b), 32'(e_we_b));
      if (e_iss_a) check("ram_aadr", 32'(ram_aadr), 32'(e_adr_a));
      if (e_iss_b) check("ram_badr", 32'(ram_badr), 32'(e_adr_b));
      if (e_we_a) check("ram_din_a", 32'(ram_din_a), 32'(e_din_a));
      if (e_we_b) check("ram_din_b", 32'(ram_din_b), 32'(e_din_b));
      check("a_rvalid", 32'(a_rvalid), 32'(rv_a[cyc]));
      check("b_rvalid", 32'(b_rvalid), 32'(rv_b[cyc]));
      if (rv_a[cyc]) check("a_rdata", 32'(a_rdata), 32'(rd_a[cyc]));
      if (rv_b[cyc]) check("b_rdata", 32'(b_rdata), 32'(rd_b[cyc]));
      check("conflict_cnt", 32'(conflict_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check("conflict_cnt_w2", 32'(cnt2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
   endtask

   // One cycle: check registered outputs, drive a request pair, check ready,
   // then advance the model by what the spec says gets accepted.
   task automatic step(input bit av, input bit awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input bit bv, input bit bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
      bit conf, ar, br, acc_a, acc_b;
      @(negedge clk);
      compare_outputs();
      a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
      b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
      #1;
      conf = av && bv && (aad == bad) && (awe || bwe);
      ar   = !conf || !m_prio;
      br   = !conf || m_prio;
      check("a_ready", 32'(a_ready), 32'(ar));
      check("b_ready", 32'(b_ready), 32'(br));
      acc_a = av && ar;
      acc_b = bv && br;
      e_iss_a = acc_a; e_we_a = acc_a && awe;
      e_iss_b = acc_b; e_we_b = acc_b && bwe;
      if (acc_a) begin e_adr_a = aad; e_din_a = awd; end
      if (acc_b) begin e_adr_b = bad; e_din_b = bwd; end
      if (acc_a && !awe) begin rv_a[cyc+2] = 1'b1; rd_a[cyc+2] = m_mem[aad]; end
      if (acc_b && !bwe) begin rv_b[cyc+2] = 1'b1; rd_b[cyc+2] = m_mem[bad]; end
      if (acc_a && awe) m_mem[aad] = awd;
      if (acc_b && bwe) m_mem[bad] = bwd;
      if (conf) begin
         m_prio = !m_prio;
         m_cnt++;
      end
      cyc++;
   endtask

   task automatic idle();
      step(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic model_reset();
      m_prio = 1'b0; m_cnt = 0;
      e_iss_a = 0; e_iss_b = 0; e_we_a = 0; e_we_b = 0;
      e_adr_a = '0; e_adr_b = '0; e_din_a = '0; e_din_b = '0;
      for (int i = 0; i < MAXC; i++) begin
         rv_a[i] = 1'b0;
         rv_b[i] = 1'b0;
      end
   endtask

   initial begin
      logic [DW-1:0] keep;
      rst = 1'b0;
      a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ram_we_a", 32'(ram_we_a), 32'd0);
      check("rst_a_ready", 32'(a_ready), 32'd1);
      check("rst_cnt", 32'(conflict_cnt), 32'd0);
      rst = 1'b1;

      // Persistent same-address write conflict alternates grants A,B,A,B.
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 4'd7, DW'(16'h7000 + i), 1, 1, 4'd7, DW'(16'h7100 + i));
         check("t3_grant_a", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("t3_grant_b", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      end
      idle();
      check("t3_cnt", 32'(conflict_cnt), 32'd4);
      check("t3_cnt_w2", 32'(cnt2), 32'd3);

      // Write then read on A: write pulse, then read data 2 cycles later.
      step(1, 1, 4'd5, 16'h1234, 0, 0, '0, '0);
      step(1, 0, 4'd5, '0, 0, 0, '0, '0);
      check("t1_we_pulse", 32'(ram_we_a), 32'd1);
      check("t1_we_addr", 32'(ram_aadr), 32'd5);
      idle();
      check("t1_we_drop", 32'(ram_we_a), 32'd0);
      idle();
      check("t1_rvalid", 32'(a_rvalid), 32'd1);
      check("t1_rdata", 32'(a_rdata), 32'h1234);

      // Same-address write-write with A favoured; B follows and wins the value.
      step(1, 1, 4'd2, 16'hAAAA, 1, 1, 4'd2, 16'hBBBB);
      check("t2_a_ready", 32'(a_ready), 32'd1);
      check("t2_b_ready", 32'(b_ready), 32'd0);
      step(0, 0, '0, '0, 1, 1, 4'd2, 16'hBBBB);
      check("t2_b_retry", 32'(b_ready), 32'd1);
      check("t2_cnt", 32'(conflict_cnt), 32'd5);
      step(1, 0, 4'd2, '0, 0, 0, '0, '0);
      idle();
      idle();
      check("t2_rdata", 32'(a_rdata), 32'hBBBB);

      // Same-address reads are not a conflict.
      step(0, 0, '0, '0, 1, 1, 4'd3, 16'h0C0C);
      step(1, 0, 4'd3, '0, 1, 0, 4'd3, '0);
      check("t4_a_ready", 32'(a_ready), 32'd1);
      check("t4_b_ready", 32'(b_ready), 32'd1);
      idle();
      idle();
      check("t4_rvalid_pair", 32'({a_rvalid, b_rvalid}), 32'd3);
      check("t4_a_rdata", 32'(a_rdata), 32'h0C0C);
      check("t4_b_rdata", 32'(b_rdata), 32'h0C0C);
      check("t4_cnt", 32'(conflict_cnt), 32'd5);

      // Read vs write with B favoured: write goes first, read sees it.
      step(1, 0, 4'd9, '0, 1, 1, 4'd9, 16'h5555);
      check("t5_a_ready", 32'(a_ready), 32'd0);
      check("t5_b_ready", 32'(b_ready), 32'd1);
      step(1, 0, 4'd9, '0, 0, 0, '0, '0);
      check("t5_a_retry", 32'(a_ready), 32'd1);
      idle();
      idle();
      check("t5_rdata", 32'(a_rdata), 32'h5555);

      // Reset with a read and a write in flight.
      step(1, 1, 4'd8, 16'h1111, 1, 1, 4'd8, 16'h2222);
      keep = m_mem[6];
      step(1, 0, 4'd5, '0, 1, 1, 4'd6, 16'h6666);
      @(posedge clk);
      #2;
      a_valid = 0; b_valid = 0;
      rst = 1'b0;
      #1;
      check("t6_we_a", 32'(ram_we_a), 32'd0);
      check("t6_we_b", 32'(ram_we_b), 32'd0);
      check("t6_aadr", 32'(ram_aadr), 32'd0);
      check("t6_cnt", 32'(conflict_cnt), 32'd0);
      check("t6_cnt_w2", 32'(cnt2), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("t6_no_rvalid", 32'(a_rvalid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      m_mem[6] = keep;

      // Counter saturation on the 2-bit instance; prio restarts at A.
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 4'd1, DW'(i), 1, 1, 4'd1, DW'(16'h0100 + i));
         if (i == 0) check("t7_first_a", 32'(a_ready), 32'd1);
      end
      idle();
      check("t7_cnt_w2", 32'(cnt2), 32'd3);
      check("t7_cnt", 32'(conflict_cnt), 32'd6);

      // Randomized traffic, biased toward shared addresses.
      for (int i = 0; i < 1500; i++) begin
         bit narrow;
         narrow = ($urandom_range(0, 1) == 1);
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              narrow ? AW'($urandom_range(0, 2)) : AW'($urandom_range(0, 15)), DW'($urandom),
              ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              narrow ? AW'($urandom_range(0, 2)) : AW'($urandom_range(0, 15)), DW'($urandom));
      end
      repeat (3) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Upstream issue stage for the team's synchronous dual-port RAM (1-cycle registered read, one write port per side, write-write same-address collision).
- Accepts independent valid/ready request streams from two clients, A and B.
- Detects same-address hazards and serialises them with round-robin priority, so the RAM never sees a same-address collision or a read-during-write.
- Registers the RAM port controls and returns read data with a fixed latency.

Parameters:
- DATA_W, 16, data width of the RAM word.
- ADDR_W, 4, address width; RAM depth is 2**ADDR_W.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- a_valid  in  1  client A request valid.
- a_ready  out  1  client A request accepted this cycle when a_valid is also high.
- a_we  in  1  client A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  client A address.
- a_wdata  in  DATA_W  client A write data.
- a_rvalid  out  1  client A read data valid.
- a_rdata  out  DATA_W  client A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as the A ports, for client B.
- ram_we_a  out  1  RAM port A write enable.
- ram_we_b  out  1  RAM port B write enable.
- ram_aadr  out  ADDR_W  RAM port A address.
- ram_badr  out  ADDR_W  RAM port B address.
- ram_din_a  out  DATA_W  RAM port A write data.
- ram_din_b  out  DATA_W  RAM port B write data.
- ram_dout_a  in  DATA_W  RAM port A read data (registered in the RAM).
- ram_dout_b  in  DATA_W  RAM port B read data (registered in the RAM).
- conflict_cnt  out  CNT_W  count of conflict cycles, saturating.

Behaviour:
- Reset (rst=0, asynchronous) clears all of the following immediately:
  - ram_we_a/b = 0, ram_aadr/badr = 0, ram_din_a/b = 0.
  - a_rvalid/b_rvalid = 0, read-pending flags = 0.
  - prio = 0 (A favoured), conflict_cnt = 0.
  - In-flight requests are dropped and no response is produced for them.
  - a_ready/b_ready are combinational and read 1 during reset only if there is no conflict; benches must not drive valid during reset.
- Conflict (combinational): a_valid & b_valid & (a_addr == b_addr) & (a_we | b_we).
  - Two reads to the same address are not a conflict.
- Ready, combinational, no dependence on response side:
  - No conflict: a_ready = b_ready = 1.
  - Conflict: the winner is A if prio == 0, otherwise B. winner_ready = 1, loser_ready = 0.
- prio update: on a conflict cycle, prio is set to point at the loser. Otherwise prio holds. A persistent conflict therefore alternates A, B, A, ...
- conflict_cnt increments by 1 on each conflict cycle and saturates at 2**CNT_W-1.
- Issue register, per port x, at edge E where x_valid & x_ready:
  - ram_we_x <= x_we, ram_xadr <= x_addr, ram_din_x <= x_wdata.
  - rd_pend_x <= ~x_we.
  - Not accepted: ram_we_x <= 0 and rd_pend_x <= 0; address and data hold.
- RAM acts at edge E+1.
- Response, per port x:
  - x_rvalid is registered: x_rvalid <= rd_pend_x at E+1, so it is high in the cycle after E+1.
  - x_rdata = ram_dout_x, wired directly.
  - Read latency is 2 cycles from acceptance. Writes produce no response.
- Throughput: one request per port per cycle when there is no conflict. Back-to-back same-address write-then-read across cycles is ordered by issue order, and the read returns the new data.
- The RAM never receives ram_we_a & ram_we_b with equal addresses, nor a read on one port and a write on the other to the same address, in the same cycle.

Test Plan:
- Reset, then A writes 0x1234 to addr 5; next cycle A reads addr 5 -> ram_we_a pulses one cycle after acceptance; a_rvalid=1 with a_rdata=0x1234 two cycles after the read is accepted.
- A writes addr 2 = 0xAAAA and B writes addr 2 = 0xBBBB in the same cycle, prio=0 -> a_ready=1, b_ready=0, conflict_cnt=1. B is accepted next cycle; a read of addr 2 afterwards returns 0xBBBB.
- A and B both write addr 7 continuously for 4 cycles -> grants alternate A, B, A, B; conflict_cnt=4; no cycle has ram_we_a & ram_we_b on equal addresses.
- A reads addr 3 while B reads addr 3 -> both ready, no conflict, conflict_cnt unchanged; both rvalid together with identical data.
- A reads addr 9 while B writes 0x5555 to addr 9, prio=1 -> B first, A next cycle; a_rdata=0x5555.
- Assert rst low while a read is in flight -> a_rvalid stays 0, ram_we_a/b drop to 0 asynchronously, conflict_cnt=0, prio=0; normal operation resumes after release.
- With CNT_W forced to 2, hold a conflict for 6 cycles -> conflict_cnt sticks at 3.
